fb_reader: RTL and testbench

// Wishbone master that reads the RGB565 framebuffer out of SDRAM in raster order (read side of the pattern writer).

---
 rtl/fb_reader_pkg.sv | 18 +
 rtl/fb_reader_if.sv | 23 ++
 rtl/fb_reader_fifo.sv | 53 +++++
 rtl/fb_reader.sv | 123 ++++++++++++
 tb/tb_fb_reader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fb_reader_pkg.sv
// Shared types for the framebuffer reader: pixel word, FIFO entry and FSM states.
package fb_pkg;

  typedef logic [15:0] pix_t;

  typedef struct packed {
    pix_t d;
    logic sof;
    logic eol;
  } fb_word_t;

  typedef enum logic [0:0] {StIdle, StReq} fb_rd_state_t;

  localparam logic [1:0] WbSelAll     = 2'b11;
  localparam logic [2:0] WbCtiClassic = 3'b000;
  localparam logic [1:0] WbBteLinear  = 2'b00;

endpackage

// File: rtl/fb_reader_if.sv
// Wishbone (16-bit data, byte addressed) bus between the reader and the SDRAM arbiter.
interface fb_reader_if;
  logic [31:0] adr;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [1:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [15:0] dat_ms;
  logic [15:0] dat_sm;
  logic        ack;

  modport master (
    output adr, stb, cyc, we, sel, cti, bte, dat_ms,
    input  dat_sm, ack
  );

  modport slave (
    input  adr, stb, cyc, we, sel, cti, bte, dat_ms,
    output dat_sm, ack
  );
endinterface

// File: rtl/fb_reader_fifo.sv
// Synchronous show-ahead FIFO with occupancy output; head is readable while not empty.
module fb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type T = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  T                           wdata_i,
  input  logic                       pop_i,
  output T                           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  // Pop on empty is dropped; push on full only lands when a pop frees the slot.
  always_comb begin
    do_pop  = pop_i && (level_q != '0);
    do_push = push_i && ((level_q != LW'(DEPTH)) || do_pop);
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= wdata_i;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign rdata_o = mem[rptr_q];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
endmodule

// File: rtl/fb_reader.sv
// Raster-order framebuffer reader: Wishbone master fetching RGB565 pixels into a FIFO
// and presenting them as a valid/ready stream with start-of-frame and end-of-line flags.
module fb_reader
  import fb_pkg::*;
#(
  parameter int unsigned HDISP      = 640,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned MAX_BURST  = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fb_reader_if.master    wshb_if_fb,
  input  logic           enable_i,
  output pix_t           pix_data_o,
  output logic           pix_valid_o,
  input  logic           pix_ready_i,
  output logic           pix_sof_o,
  output logic           pix_eol_o
);
  localparam int unsigned XW = $clog2(HDISP);
  localparam int unsigned YW = $clog2(VDISP);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  fb_rd_state_t  state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] burst_q, burst_d;

  logic          push, pop, fifo_empty;
  logic [LW-1:0] level;
  logic [LW:0]   level_post;
  fb_word_t      wr_word, head;
  logic [31:0]   lin_idx;

  assign pop        = pix_valid_o && pix_ready_i;
  assign level_post = {1'b0, level} + (LW + 1)'(1) - (LW + 1)'(pop);

  // Next-state: fetch request, pixel counters and burst accounting.
  // Leaving REQ is registered, so every release keeps cyc low for at least one
  // IDLE cycle; that cycle is the cooldown that lets other masters win arbitration.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    burst_d     = burst_q;
    push        = 1'b0;
    wr_word.d   = wshb_if_fb.dat_sm;
    wr_word.sof = (x_q == '0) && (y_q == '0);
    wr_word.eol = (x_q == XW'(HDISP - 1));
    unique case (state_q)
      StIdle: begin
        burst_d = '0;
        if (enable_i && (level <= LW'(FIFO_DEPTH - 2))) state_d = StReq;
      end
      StReq: begin
        if (wshb_if_fb.ack) begin
          push = 1'b1;
          if (x_q == XW'(HDISP - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(VDISP - 1)) ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (!enable_i || (level_post > (LW + 1)'(FIFO_DEPTH - 2)) ||
              (burst_q == BW'(MAX_BURST - 1))) begin
            state_d = StIdle;
            burst_d = '0;
          end else begin
            burst_d = burst_q + BW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pixel position and burst counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      burst_q <= burst_d;
    end
  end

  fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fb_word_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wr_word),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign lin_idx = 32'(y_q) * 32'(HDISP) + 32'(x_q);

  assign wshb_if_fb.adr    = {lin_idx[30:0], 1'b0};
  assign wshb_if_fb.cyc    = (state_q == StReq);
  assign wshb_if_fb.stb    = (state_q == StReq);
  assign wshb_if_fb.we     = 1'b0;
  assign wshb_if_fb.sel    = WbSelAll;
  assign wshb_if_fb.cti    = WbCtiClassic;
  assign wshb_if_fb.bte    = WbBteLinear;
  assign wshb_if_fb.dat_ms = 16'h0000;

  assign pix_valid_o = !fifo_empty;
  assign pix_data_o  = head.d;
  assign pix_sof_o   = !fifo_empty && head.sof;
  assign pix_eol_o   = !fifo_empty && head.eol;
endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader: small 8x4 frame, 16-entry FIFO, 4-ack bursts, variable-latency slave.
module tb_fb_reader;
  import fb_pkg::*;

  localparam int unsigned HDISP      = 8;
  localparam int unsigned VDISP      = 4;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned MAX_BURST  = 4;
  localparam int unsigned NPIX       = HDISP * VDISP;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic pix_ready = 1'b0;
  pix_t pix_data;
  logic pix_valid, pix_sof, pix_eol;

  fb_reader_if wshb_if_fb ();

  fb_reader #(
    .HDISP      (HDISP),
    .VDISP      (VDISP),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_BURST  (MAX_BURST)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wshb_if_fb  (wshb_if_fb),
    .enable_i    (enable),
    .pix_data_o  (pix_data),
    .pix_valid_o (pix_valid),
    .pix_ready_i (pix_ready),
    .pix_sof_o   (pix_sof),
    .pix_eol_o   (pix_eol)
  );

  always #5 clk = ~clk;

  // Slave: acks after 'delay' wait cycles, returns the pixel index as data.
  int unsigned delay = 0;
  int unsigned wait_cnt;
  assign wshb_if_fb.ack    = wshb_if_fb.cyc && wshb_if_fb.stb && (wait_cnt >= delay);
  assign wshb_if_fb.dat_sm = wshb_if_fb.adr[16:1];

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (wshb_if_fb.stb && !wshb_if_fb.ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Reference model state: FIFO occupancy, next pixel fetched, next pixel delivered.
  int          n_tests = 0;
  int          n_fail = 0;
  int          lvl = 0;
  int          fetch_idx = 0;
  int          pop_idx = 0;
  int          ack_cnt = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_adr = '0;
  bit          cyc_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    lvl       = 0;
    fetch_idx = 0;
    pop_idx   = 0;
    prev_wait = 1'b0;
  endtask

  // One clock: check the current cycle at the falling edge, then step past the rising edge.
  task automatic tick();
    logic pop, push;
    @(negedge clk);
    if (!rst) begin
      chk("pix_valid", 32'(pix_valid), 32'(lvl != 0));
      pop  = pix_valid && pix_ready;
      push = wshb_if_fb.ack;
      if (pix_valid) begin
        chk("pix_data", 32'(pix_data), pop_idx);
        chk("pix_sof", 32'(pix_sof), 32'(pop_idx == 0));
        chk("pix_eol", 32'(pix_eol), 32'((pop_idx % HDISP) == HDISP - 1));
      end else begin
        chk("sof_idle", 32'(pix_sof), 0);
        chk("eol_idle", 32'(pix_eol), 0);
      end
      if (prev_wait) begin
        chk("stb_hold", 32'(wshb_if_fb.stb), 1);
        chk("adr_hold", wshb_if_fb.adr, prev_adr);
      end
      if (push) begin
        chk("adr", wshb_if_fb.adr, 2 * fetch_idx);
        chk("we", 32'(wshb_if_fb.we), 0);
        chk("sel", 32'(wshb_if_fb.sel), 3);
        chk("cti_bte", {27'd0, wshb_if_fb.cti, wshb_if_fb.bte}, 0);
        chk("dat_ms", 32'(wshb_if_fb.dat_ms), 0);
        chk("fifo_room", 32'((lvl < FIFO_DEPTH) || pop), 1);
        fetch_idx = (fetch_idx + 1) % NPIX;
        ack_cnt++;
      end
      if (pop) pop_idx = (pop_idx + 1) % NPIX;
      lvl       = lvl + int'(push) - int'(pop);
      prev_wait = wshb_if_fb.stb && !wshb_if_fb.ack;
      prev_adr  = wshb_if_fb.adr;
      cyc_hist.push_back(wshb_if_fb.cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(input int max);
    int n = 0;
    while (wshb_if_fb.stb !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("wait_stb", 32'(wshb_if_fb.stb), 1);
  endtask

  task automatic wait_ack(input int max);
    int n = 0;
    while (wshb_if_fb.ack !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("wait_ack", 32'(wshb_if_fb.ack), 1);
  endtask

  initial begin
    logic [31:0] a0;
    int          drop;
    int          n;

    // Reset state.
    #2 rst = 1'b1;
    tick();
    tick();
    chk("rst_stb", 32'(wshb_if_fb.stb), 0);
    chk("rst_cyc", 32'(wshb_if_fb.cyc), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_sof", 32'(pix_sof), 0);
    chk("rst_eol", 32'(pix_eol), 0);
    rst = 1'b0;
    reset_model();

    // Free-running stream across several frames.
    enable    = 1'b1;
    pix_ready = 1'b1;
    for (int i = 0; i < 100; i++) tick();

    // Burst shape: four acks then exactly one idle cycle.
    cyc_hist.delete();
    for (int i = 0; i < 40; i++) tick();
    drop = -1;
    for (int i = 1; i < 10; i++) begin
      if (drop < 0 && cyc_hist[i] == 1'b0 && cyc_hist[i-1] == 1'b1) drop = i;
    end
    chk("burst_found", 32'(drop >= 0), 1);
    if (drop < 0) drop = 0;
    for (int k = 0; k < 20; k++) begin
      chk("burst_pat", 32'(cyc_hist[drop + k]), 32'((k % 5) != 0));
    end

    // Consumer stall: FIFO fills to DEPTH-1 and fetching parks.
    enable = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("drained", 32'(pix_valid), 0);
    pix_ready = 1'b0;
    ack_cnt   = 0;
    enable    = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    chk("stall_acks", ack_cnt, FIFO_DEPTH - 1);
    chk("stall_cyc", 32'(wshb_if_fb.cyc), 0);
    pix_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    // Enable dropped during a slow access.
    enable = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    delay  = 5;
    enable = 1'b1;
    wait_stb(20);
    tick();
    tick();
    enable = 1'b0;
    a0     = wshb_if_fb.adr;
    wait_ack(20);
    tick();
    chk("drop_cyc", 32'(wshb_if_fb.cyc), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("drop_cyc_hold", 32'(wshb_if_fb.cyc), 0);
    enable = 1'b1;
    wait_stb(20);
    chk("resume_adr", wshb_if_fb.adr, 2 * (((a0 / 2) + 1) % NPIX));

    // Randomised traffic: ready, ack latency and enable all vary.
    for (int i = 0; i < 1500; i++) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) delay = $urandom_range(0, 4);
      if ($urandom_range(0, 40) == 0) enable = !enable;
      tick();
    end
    pix_ready = 1'b1;
    enable    = 1'b1;

    // Asynchronous reset in the middle of a pending access.
    delay = 3;
    wait_stb(40);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_stb", 32'(wshb_if_fb.stb), 0);
    chk("arst_cyc", 32'(wshb_if_fb.cyc), 0);
    chk("arst_valid", 32'(pix_valid), 0);
    reset_model();
    tick();
    tick();
    rst = 1'b0;
    wait_ack(20);
    chk("arst_adr", wshb_if_fb.adr, 0);
    n = 0;
    while (pix_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("arst_first_sof", 32'(pix_sof), 1);
    chk("arst_first_data", 32'(pix_data), 0);
    for (int i = 0; i < 60; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
